// File: rtl/fall_animator.sv
// Fall animation for the ball: freezes physics, sinks the sprite into the hole,
// hides it for a hold time, then presents the win/fail result until acknowledged.
module fall_animator #(
   parameter int RADIUS      = 16,
   parameter int MIN_RADIUS  = 2,
   parameter int STEP_FRAMES = 4,
   parameter int HOLD_FRAMES = 30
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_frame_tick,
   input  logic       i_win,
   input  logic       i_fail,
   input  logic [9:0] i_pos_fall_x,
   input  logic [9:0] i_pos_fall_y,
   input  logic [9:0] i_bl_x,
   input  logic [9:0] i_bl_y,
   input  logic       i_ack,
   output logic [9:0] o_ball_x,
   output logic [9:0] o_ball_y,
   output logic [5:0] o_ball_r,
   output logic       o_ball_visible,
   output logic       o_freeze,
   output logic       o_busy,
   output logic       o_result_valid,
   output logic       o_result_win
);

   typedef enum logic [1:0] {IDLE, SINK, HOLD, REPORT} state_t;

   localparam int CNT_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [5:0] R_REST = 6'(RADIUS);
   localparam logic [5:0] R_MIN  = 6'(MIN_RADIUS);

   // Halve the distance each step; within one pixel, snap onto the target.
   function automatic logic [9:0] approach(input logic [9:0] pos, input logic [9:0] tgt);
      logic signed [10:0] d;
      d = signed'({1'b0, tgt}) - signed'({1'b0, pos});
      if (d >= 11'sd2 || d <= -11'sd2)
         approach = pos + 10'(d >>> 1);
      else
         approach = pos + d[9:0];
   endfunction

   state_t           state_reg, state_next;
   logic [9:0]       x_reg, x_next, y_reg, y_next;
   logic [9:0]       tx_reg, tx_next, ty_reg, ty_next;
   logic [5:0]       r_reg, r_next;
   logic             vis_reg, vis_next;
   logic             freeze_reg, freeze_next;
   logic             busy_reg, busy_next;
   logic             valid_reg, valid_next;
   logic             res_win_reg, res_win_next;
   logic             win_lat_reg, win_lat_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [9:0]       step_x, step_y;
   logic [5:0]       step_r;

   assign step_x = approach(x_reg, tx_reg);
   assign step_y = approach(y_reg, ty_reg);
   assign step_r = (r_reg > R_MIN) ? r_reg - 6'd1 : r_reg;

   always_comb begin
      state_next   = state_reg;
      x_next       = x_reg;
      y_next       = y_reg;
      tx_next      = tx_reg;
      ty_next      = ty_reg;
      r_next       = r_reg;
      vis_next     = vis_reg;
      valid_next   = valid_reg;
      res_win_next = res_win_reg;
      win_lat_next = win_lat_reg;
      cnt_next     = cnt_reg;
      case (state_reg)
         IDLE: begin
            x_next   = i_bl_x;
            y_next   = i_bl_y;
            r_next   = R_REST;
            vis_next = 1'b1;
            if (i_win | i_fail) begin
               tx_next      = i_pos_fall_x;
               ty_next      = i_pos_fall_y;
               win_lat_next = i_win;
               cnt_next     = '0;
               state_next   = SINK;
            end
         end
         SINK: begin
            if (i_frame_tick) begin
               if (cnt_reg == STEP_LAST) begin
                  cnt_next = '0;
                  x_next   = step_x;
                  y_next   = step_y;
                  r_next   = step_r;
                  if (step_x == tx_reg && step_y == ty_reg && step_r == R_MIN) begin
                     vis_next   = 1'b0;
                     state_next = HOLD;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (i_frame_tick) begin
               if (cnt_reg == HOLD_LAST) begin
                  cnt_next     = '0;
                  valid_next   = 1'b1;
                  res_win_next = win_lat_reg;
                  state_next   = REPORT;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         REPORT: begin
            if (i_ack) begin
               valid_next   = 1'b0;
               res_win_next = 1'b0;
               r_next       = R_REST;
               vis_next     = 1'b1;
               x_next       = i_bl_x;
               y_next       = i_bl_y;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Freeze/busy follow the state being entered so they stay registered.
      freeze_next = (state_next != IDLE);
      busy_next   = (state_next != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg   <= IDLE;
         x_reg       <= '0;
         y_reg       <= '0;
         tx_reg      <= '0;
         ty_reg      <= '0;
         r_reg       <= R_REST;
         vis_reg     <= 1'b1;
         freeze_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         valid_reg   <= 1'b0;
         res_win_reg <= 1'b0;
         win_lat_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         x_reg       <= x_next;
         y_reg       <= y_next;
         tx_reg      <= tx_next;
         ty_reg      <= ty_next;
         r_reg       <= r_next;
         vis_reg     <= vis_next;
         freeze_reg  <= freeze_next;
         busy_reg    <= busy_next;
         valid_reg   <= valid_next;
         res_win_reg <= res_win_next;
         win_lat_reg <= win_lat_next;
         cnt_reg     <= cnt_next;
      end
   end

   assign o_ball_x       = x_reg;
   assign o_ball_y       = y_reg;
   assign o_ball_r       = r_reg;
   assign o_ball_visible = vis_reg;
   assign o_freeze       = freeze_reg;
   assign o_busy         = busy_reg;
   assign o_result_valid = valid_reg;
   assign o_result_win   = res_win_reg;

endmodule

// File: tb/tb_fall_animator.sv
// Bench for fall_animator: two instances (one step per tick, and four ticks per
// step) driven with shared stimulus and compared every cycle against a model.
module tb_fall_animator;

   logic       clk = 1'b0;
   logic       rst, tick, win, fail, ack;
   logic [9:0] pfx, pfy, blx, bly;

   logic [9:0] a_x, a_y, b_x, b_y;
   logic [5:0] a_r, b_r;
   logic       a_vis, a_frz, a_busy, a_valid, a_win;
   logic       b_vis, b_frz, b_busy, b_valid, b_win;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   fall_animator #(.RADIUS(16), .MIN_RADIUS(2), .STEP_FRAMES(1), .HOLD_FRAMES(3)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_win(win), .i_fail(fail),
      .i_pos_fall_x(pfx), .i_pos_fall_y(pfy), .i_bl_x(blx), .i_bl_y(bly), .i_ack(ack),
      .o_ball_x(a_x), .o_ball_y(a_y), .o_ball_r(a_r), .o_ball_visible(a_vis),
      .o_freeze(a_frz), .o_busy(a_busy), .o_result_valid(a_valid), .o_result_win(a_win));

   fall_animator #(.RADIUS(16), .MIN_RADIUS(2), .STEP_FRAMES(4), .HOLD_FRAMES(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_win(win), .i_fail(fail),
      .i_pos_fall_x(pfx), .i_pos_fall_y(pfy), .i_bl_x(blx), .i_bl_y(bly), .i_ack(ack),
      .o_ball_x(b_x), .o_ball_y(b_y), .o_ball_r(b_r), .o_ball_visible(b_vis),
      .o_freeze(b_frz), .o_busy(b_busy), .o_result_valid(b_valid), .o_result_win(b_win));

   // phase: 0 idle, 1 sinking, 2 hidden, 3 reporting
   typedef struct {
      int phase; int x; int y; int r; int tx; int ty; int ticks;
      bit vis; bit valid; bit win; bit wl; bit pos_dc;
   } mstate_t;

   mstate_t ma, mb;

   function automatic int toward(input int p, input int t);
      int d;
      d = t - p;
      if (d >= 2) return p + d / 2;
      if (d <= -2) return p - ((1 - d) / 2);
      return t;
   endfunction

   function automatic mstate_t mstep(input mstate_t s, input int sf, input int hf);
      mstate_t m;
      m = s;
      m.pos_dc = 1'b0;
      if (rst) begin
         m.phase = 0; m.x = 0; m.y = 0; m.r = 16; m.ticks = 0;
         m.vis = 1'b1; m.valid = 1'b0; m.win = 1'b0;
         return m;
      end
      case (m.phase)
         0: begin
            m.x = blx; m.y = bly; m.r = 16; m.vis = 1'b1;
            if (win || fail) begin
               m.tx = pfx; m.ty = pfy; m.wl = win; m.ticks = 0; m.phase = 1;
            end
         end
         1: if (tick) begin
            m.ticks++;
            if (m.ticks == sf) begin
               m.ticks = 0;
               m.x = toward(m.x, m.tx);
               m.y = toward(m.y, m.ty);
               if (m.r > 2) m.r--;
               if (m.x == m.tx && m.y == m.ty && m.r == 2) begin
                  m.vis = 1'b0; m.phase = 2;
               end
            end
         end
         2: if (tick) begin
            m.ticks++;
            if (m.ticks == hf) begin
               m.ticks = 0; m.phase = 3; m.valid = 1'b1; m.win = m.wl;
            end
         end
         default: if (ack) begin
            m.phase = 0; m.valid = 1'b0; m.win = 1'b0; m.r = 16; m.vis = 1'b1;
            m.x = blx; m.y = bly; m.pos_dc = 1'b1;
         end
      endcase
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input mstate_t m, input logic [9:0] x, input logic [9:0] y,
                      input logic [5:0] r, input logic vis, input logic frz, input logic busy,
                      input logic valid, input logic w);
      if (!m.pos_dc) begin
         check({tag, ".x"}, 32'(x), m.x);
         check({tag, ".y"}, 32'(y), m.y);
      end
      check({tag, ".r"}, 32'(r), m.r);
      check({tag, ".visible"}, 32'(vis), 32'(m.vis));
      check({tag, ".freeze"}, 32'(frz), 32'(m.phase != 0));
      check({tag, ".busy"}, 32'(busy), 32'(m.phase != 0));
      check({tag, ".valid"}, 32'(valid), 32'(m.valid));
      check({tag, ".win"}, 32'(w), 32'(m.win));
   endtask

   always @(posedge clk) begin
      mstate_t pa, pb;
      pa = ma; pb = mb;
      ma = mstep(ma, 1, 3);
      mb = mstep(mb, 4, 3);
      if (checking && pa.phase == 2 && ma.phase == 3)
         $display("txn a: result reported win=%0d target=(%0d,%0d)", ma.win, ma.tx, ma.ty);
      if (checking && pb.phase == 2 && mb.phase == 3)
         $display("txn b: result reported win=%0d target=(%0d,%0d)", mb.win, mb.tx, mb.ty);
   end

   always @(negedge clk) begin
      if (checking) begin
         cmp("a", ma, a_x, a_y, a_r, a_vis, a_frz, a_busy, a_valid, a_win);
         cmp("b", mb, b_x, b_y, b_r, b_vis, b_frz, b_busy, b_valid, b_win);
      end
   end

   task automatic step_clk;
      @(posedge clk);
      #2;
   endtask

   // One frame tick followed by an idle cycle; outputs are read between them.
   task automatic frame;
      tick = 1'b1;
      step_clk();
      tick = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
   endtask

   int xs [5] = '{105, 107, 108, 109, 110};
   int ys [5] = '{98, 97, 96, 96, 96};

   initial begin
      rst = 1'b1; tick = 1'b0; win = 1'b0; fail = 1'b0; ack = 1'b0;
      pfx = '0; pfy = '0; blx = '0; bly = '0;
      step_clk();
      checking = 1'b1;
      step_clk();
      check("reset.x", 32'(a_x), 0);
      check("reset.r", 32'(a_r), 16);
      check("reset.visible", 32'(a_vis), 1);
      check("reset.freeze", 32'(a_frz), 0);
      check("reset.valid", 32'(a_valid), 0);
      rst = 1'b0;

      // Fall into a fail hole at (110,96) from (100,100).
      blx = 10'd100; bly = 10'd100;
      step_clk();
      check("idle_track.x", 32'(a_x), 100);
      pfx = 10'd110; pfy = 10'd96; fail = 1'b1;
      step_clk();
      fail = 1'b0;
      check("trigger.freeze", 32'(a_frz), 1);
      check("trigger.x", 32'(a_x), 100);
      for (int k = 1; k <= 14; k++) begin
         frame();
         if (k <= 5) begin
            check("sink.x", 32'(a_x), xs[k-1]);
            check("sink.y", 32'(a_y), ys[k-1]);
         end
         check("sink.r", 32'(a_r), 16 - k);
         if (k < 4) check("slow.hold_x", 32'(b_x), 100);
         if (k == 4) check("slow.step_x", 32'(b_x), 105);
         step_clk();
      end
      check("sink.end_r", 32'(a_r), 2);
      check("sink.hidden", 32'(a_vis), 0);
      for (int k = 1; k <= 3; k++) begin
         frame();
         check("hold.valid", 32'(a_valid), (k == 3) ? 1 : 0);
         step_clk();
      end
      check("report.win", 32'(a_win), 0);

      // No ticks: slow instance frozen mid-animation; fail toggling ignored.
      for (int i = 0; i < 100; i++) begin
         fail = i[0];
         step_clk();
      end
      check("no_tick.x", 32'(b_x), 109);
      check("no_tick.r", 32'(b_r), 12);
      for (int i = 0; i < 5; i++) begin
         fail = ~fail;
         frame();
      end
      fail = 1'b0;
      check("report_hold.valid", 32'(a_valid), 1);
      check("report_hold.x", 32'(a_x), 110);
      ack = 1'b1;
      step_clk();
      ack = 1'b0;
      check("ack.valid", 32'(a_valid), 0);
      check("ack.r", 32'(a_r), 16);
      check("ack.visible", 32'(a_vis), 1);
      check("ack.freeze", 32'(a_frz), 0);
      blx = 10'd200; bly = 10'd300;
      step_clk();
      check("ack.track_x", 32'(a_x), 200);
      check("ack.track_y", 32'(a_y), 300);

      // Reset in the middle of sinking, then restart; acks during sink/hold ignored.
      do_reset();
      blx = 10'd100; bly = 10'd100; pfx = 10'd110; pfy = 10'd96;
      step_clk();
      fail = 1'b1;
      step_clk();
      fail = 1'b0;
      for (int k = 0; k < 7; k++) begin
         frame();
         step_clk();
      end
      check("mid_sink.r", 32'(a_r), 9);
      do_reset();
      check("mid_rst.x", 32'(a_x), 0);
      check("mid_rst.y", 32'(a_y), 0);
      check("mid_rst.r", 32'(a_r), 16);
      check("mid_rst.visible", 32'(a_vis), 1);
      check("mid_rst.freeze", 32'(a_frz), 0);
      check("mid_rst.valid", 32'(a_valid), 0);
      fail = 1'b1;
      step_clk();
      fail = 1'b0;
      frame();
      check("restart.x", 32'(a_x), 105);
      check("restart.r", 32'(a_r), 15);
      step_clk();
      for (int k = 0; k < 15; k++) begin
         ack = 1'b1;
         frame();
         step_clk();
      end
      ack = 1'b0;
      frame();
      check("late_ack.valid", 32'(a_valid), 1);
      repeat (4) step_clk();
      check("late_ack.held", 32'(a_valid), 1);
      ack = 1'b1;
      step_clk();
      ack = 1'b0;
      check("late_ack.cleared", 32'(a_valid), 0);

      // Win and fail together: win takes priority, ball already on target.
      do_reset();
      blx = 10'd50; bly = 10'd50; pfx = 10'd50; pfy = 10'd50;
      step_clk();
      win = 1'b1; fail = 1'b1;
      step_clk();
      win = 1'b0; fail = 1'b0;
      for (int k = 0; k < 14; k++) begin
         frame();
         check("both.x", 32'(a_x), 50);
         step_clk();
      end
      check("both.r", 32'(a_r), 2);
      repeat (3) begin
         frame();
         step_clk();
      end
      check("both.valid", 32'(a_valid), 1);
      check("both.win", 32'(a_win), 1);

      // Randomized traffic checked by the per-cycle model comparison.
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         tick = ($urandom_range(2) == 0);
         win  = ($urandom_range(39) == 0);
         fail = ($urandom_range(29) == 0);
         ack  = ($urandom_range(5) == 0);
         rst  = ($urandom_range(999) == 0);
         blx  = 10'($urandom_range(1023));
         bly  = 10'($urandom_range(1023));
         pfx  = 10'($urandom_range(1023));
         pfy  = 10'($urandom_range(1023));
         step_clk();
      end
      rst = 1'b0; tick = 1'b0; win = 1'b0; fail = 1'b0; ack = 1'b0;
      step_clk();
      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fall_animator.md
Name: fall_animator

Overview:
Consumer of the hole detector's win/fail result. On a fall event it freezes ball physics and animates the ball sprite into the hole: position converges on the hole centre while the radius shrinks. It then hides the ball, waits a hold time, and reports the result to the game controller until acknowledged. It sits between the hole detector and the game FSM / sprite renderer.

Parameters:
RADIUS, 16, ball radius in pixels at rest (6-bit range, 1..63)
MIN_RADIUS, 2, final radius before the ball is hidden (< RADIUS)
STEP_FRAMES, 4, frame ticks per animation step (>=1)
HOLD_FRAMES, 30, frame ticks the ball stays hidden before the result is reported (>=1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset
i_frame_tick  in  1  one-cycle pulse per video frame
i_win  in  1  ball in win hole (level)
i_fail  in  1  ball in any fail hole (level)
i_pos_fall_x  in  10  target hole centre x
i_pos_fall_y  in  10  target hole centre y
i_bl_x  in  10  live ball x from physics
i_bl_y  in  10  live ball y from physics
i_ack  in  1  game controller accepts the result
o_ball_x  out  10  sprite x
o_ball_y  out  10  sprite y
o_ball_r  out  6  sprite radius
o_ball_visible  out  1  sprite enable
o_freeze  out  1  halt physics/tilt input
o_busy  out  1  animation or report in progress
o_result_valid  out  1  result pending
o_result_win  out  1  1 = win, 0 = fail; meaningful only while o_result_valid is high

Behaviour:
- Interface (already decided): one clock, i_clk. Reset i_rst is synchronous and active-high.
- Every output is registered.
- Reset values:
  - o_ball_x = 0, o_ball_y = 0
  - o_ball_r = RADIUS, o_ball_visible = 1
  - o_freeze = 0, o_busy = 0
  - o_result_valid = 0, o_result_win = 0
  - state = IDLE, all counters = 0
- Reset mid-operation: state returns to IDLE on the next edge. Any latched result is discarded.
- States: IDLE, SINK, HOLD, REPORT.
- In every state except IDLE: o_freeze = 1 and o_busy = 1.
- IDLE:
  - o_ball_x/y <= i_bl_x/y each cycle (one-cycle latency).
  - o_ball_r = RADIUS, o_ball_visible = 1.
  - Trigger is (i_win | i_fail) sampled at the edge. On trigger: latch target <= i_pos_fall_x/y, latch win <= i_win (win has priority when both are high), load o_ball_x/y <= i_bl_x/y, clear the tick counter, go to SINK.
  - A frame tick coinciding with the trigger is not counted.
- SINK:
  - Tick counter counts i_frame_tick pulses. A step occurs on the tick where the count equals STEP_FRAMES-1; the counter then wraps to 0.
  - Per step, per axis: d = target − pos, as an 11-bit signed value. If |d| >= 2, pos += d >>> 1 (arithmetic shift). Otherwise pos += d (snap).
  - Per step, radius: if r > MIN_RADIUS, r -= 1.
  - Exit condition, evaluated after the step update: x == tx, y == ty and r == MIN_RADIUS. On exit: o_ball_visible <= 0, clear the counter, go to HOLD.
- HOLD: count HOLD_FRAMES frame ticks. On the last one go to REPORT and set o_result_valid <= 1, o_result_win <= latched win.
- REPORT:
  - Outputs hold until i_ack is high at an edge.
  - On ack: next cycle is IDLE with o_result_valid = 0, o_result_win = 0, o_ball_r = RADIUS, o_ball_visible = 1, o_freeze = 0, o_busy = 0.
- i_win/i_fail are ignored outside IDLE.
- i_ack is ignored outside REPORT.
- Targets and positions are 0..1023. No wrap occurs, because each step moves strictly toward the target.

Test Plan:
- Default parameters except STEP_FRAMES=1, HOLD_FRAMES=3; ball at (100,100); i_fail pulse with target (110,96):
  - x per step: 105, 107, 108, 109, 110.
  - y per step: 98, 97, 96, then holds.
  - r: 15, 14, … down to 2 at step 14.
  - Then o_ball_visible = 0; 3 ticks later o_result_valid = 1, o_result_win = 0.
  - o_freeze = 1 from the cycle after the trigger.
- i_win and i_fail high in the same cycle, target (50,50), ball (50,50) -> position constant, r reaches 2 after 14 steps, result reported with o_result_win = 1.
- In REPORT, i_fail toggled and frame ticks applied -> no output change. i_ack = 1 -> next cycle IDLE: o_result_valid = 0, r = 16, visible = 1, o_freeze = 0, o_ball_x/y tracking i_bl after 1 cycle.
- STEP_FRAMES=4 -> position/radius change only on every 4th i_frame_tick. No change on the 3 ticks between steps, and no change without ticks (i_frame_tick held 0 for 100 cycles).
- i_rst asserted mid-SINK (r = 9) -> next cycle: all outputs at reset values (x = y = 0, r = 16, visible = 1, freeze = 0, valid = 0), state IDLE. The next trigger animates from scratch.
- i_ack pulsed during SINK and HOLD -> ignored. Result still reported and held until a later ack.
